// File: rtl/spi_cmd_fifo.sv
// Instruction queue feeding the SPI master: host pushes packed command words,
// a 3-state presenter hands them to the master one at a time.
module spi_cmd_fifo #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 7,
  parameter int DEPTH  = 16,
  localparam int CWIDTH = DWIDTH + AWIDTH + 5,
  localparam int LWIDTH = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              host_wr_en,
  input  logic [CWIDTH-1:0] host_wdata,
  output logic              host_full,
  output logic [LWIDTH-1:0] host_level,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_in,
  input  logic              master_read,
  output logic              master_en,
  output logic [CWIDTH-1:0] master_data,
  output logic [1:0]        master_cfg,
  output logic              overflow,
  output logic              underflow
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, VALID} state_t;

  state_t            state, state_nxt;
  logic [CWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CWIDTH-1:0] rdata;
  logic [LWIDTH-1:0] level_nxt;
  logic              push_ok, rd_issue, lvl_nz;

  // Full is judged on the registered flag, so a same-edge read never rescues a push.
  assign push_ok   = host_wr_en && !host_full;
  assign lvl_nz    = (host_level != '0);
  assign master_en = (state == VALID);

  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (lvl_nz) begin
          rd_issue  = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = VALID;
      VALID: begin
        if (master_read) begin
          if (lvl_nz) begin
            rd_issue  = 1'b1;
            state_nxt = LOAD;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    level_nxt = host_level;
    case ({push_ok, rd_issue})
      2'b10:   level_nxt = host_level + LWIDTH'(1);
      2'b01:   level_nxt = host_level - LWIDTH'(1);
      default: level_nxt = host_level;
    endcase
  end

  // Storage array carries no reset; only pointers define what is live.
  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wptr] <= host_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      host_level  <= '0;
      host_full   <= 1'b0;
      rdata       <= '0;
      master_data <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else if (flush) begin
      state       <= IDLE;
      wptr        <= '0;
      rptr        <= '0;
      host_level  <= '0;
      host_full   <= 1'b0;
      rdata       <= '0;
      master_data <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      state      <= state_nxt;
      host_level <= level_nxt;
      host_full  <= (level_nxt == LWIDTH'(DEPTH));
      if (push_ok)
        wptr <= wptr + PW'(1);
      if (rd_issue) begin
        rdata <= mem[rptr];
        rptr  <= rptr + PW'(1);
      end
      if (state == LOAD)
        master_data <= rdata;
      if (host_wr_en && host_full)
        overflow <= 1'b1;
      if (master_read && state != VALID)
        underflow <= 1'b1;
    end
  end

  // Mode changes only land while nothing is queued or in flight; flush keeps them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      master_cfg <= 2'b00;
    else if (!flush && cfg_wr && state == IDLE && !lvl_nz)
      master_cfg <= cfg_in;
  end

endmodule

// File: tb/tb_spi_cmd_fifo.sv
// Scoreboard bench for spi_cmd_fifo: accepted pushes queue expected words,
// master-side consumption pops and compares.
module tb_spi_cmd_fifo;
  localparam int DWIDTH = 8;
  localparam int AWIDTH = 7;
  localparam int DEPTH  = 16;
  localparam int CWIDTH = DWIDTH + AWIDTH + 5;
  localparam int LWIDTH = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              host_wr_en = 1'b0;
  logic [CWIDTH-1:0] host_wdata = '0;
  logic              cfg_wr = 1'b0;
  logic [1:0]        cfg_in = 2'b00;
  logic              master_read = 1'b0;
  logic              host_full, master_en, overflow, underflow;
  logic [LWIDTH-1:0] host_level;
  logic [CWIDTH-1:0] master_data;
  logic [1:0]        master_cfg;

  spi_cmd_fifo #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .host_wr_en(host_wr_en), .host_wdata(host_wdata),
    .host_full(host_full), .host_level(host_level),
    .cfg_wr(cfg_wr), .cfg_in(cfg_in),
    .master_read(master_read), .master_en(master_en),
    .master_data(master_data), .master_cfg(master_cfg),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [CWIDTH-1:0] sb [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [CWIDTH-1:0] w, input bit accept);
    host_wr_en = 1'b1;
    host_wdata = w;
    tick();
    host_wr_en = 1'b0;
    if (accept) sb.push_back(w);
  endtask

  task automatic wait_en();
    int n = 0;
    while (!master_en && n < 20) begin
      tick();
      n++;
    end
    if (!master_en) chk("en_timeout", 0, 1);
  endtask

  task automatic consume(input string tag);
    logic [CWIDTH-1:0] exp;
    wait_en();
    if (master_en) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 0, 1);
      end else begin
        exp = sb.pop_front();
        chk(tag, master_data, exp);
      end
      master_read = 1'b1;
      tick();
      master_read = 1'b0;
    end
  endtask

  initial begin
    logic [CWIDTH-1:0] w;

    // reset with push strobe held active
    host_wr_en = 1'b1;
    host_wdata = 20'hABCDE;
    repeat (3) tick();
    chk("rst_en", master_en, 0);
    chk("rst_data", master_data, 0);
    chk("rst_level", host_level, 0);
    chk("rst_full", host_full, 0);
    host_wr_en = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rel_level", host_level, 0);
    chk("rel_ovf", overflow, 0);
    chk("rel_unf", underflow, 0);
    chk("rel_cfg", master_cfg, 0);
    cfg_wr = 1'b1;
    cfg_in = 2'b11;
    tick();
    cfg_wr = 1'b0;
    chk("cfg_load", master_cfg, 3);

    // single word: SS=3 WDATA=A5 ADDR=55 SIZE=2 WR_EN=1
    w = {2'd3, 8'hA5, 7'h55, 2'd2, 1'b1};
    push(w, 1'b1);
    chk("sw_lvl1", host_level, 1);
    chk("sw_en_k", master_en, 0);
    tick();
    chk("sw_lvl0", host_level, 0);
    chk("sw_en_k1", master_en, 0);
    tick();
    chk("sw_en_k2", master_en, 1);
    chk("sw_data", master_data, sb.pop_front());
    master_read = 1'b1;
    tick();
    master_read = 1'b0;
    chk("sw_fall", master_en, 0);
    tick();
    chk("sw_low1", master_en, 0);
    tick();
    chk("sw_low2", master_en, 0);

    // fill to full, then overflow
    for (int i = 0; i < 17; i++) begin
      push(CWIDTH'(20'h40000 + i * 3), 1'b1);
      if (i == 15) begin
        chk("fill_lvl15", host_level, 15);
        chk("fill_nfull", host_full, 0);
      end
    end
    chk("fill_lvl16", host_level, 16);
    chk("fill_full", host_full, 1);
    chk("fill_noovf", overflow, 0);
    push(20'hFFFFF, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_lvl", host_level, 16);
    consume("fill_d0");
    chk("drain_nfull", host_full, 0);
    for (int i = 1; i < 17; i++) consume("fill_data");
    repeat (3) tick();
    chk("drain_lvl", host_level, 0);
    chk("drain_en", master_en, 0);
    chk("ovf_sticky", overflow, 1);

    // stream 40 words across pointer wrap with overlapping push/read
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push(CWIDTH'(i * 1237 + 77), 1'b1);
          if (i % 2 == 1) tick();
        end
      end
      begin
        int got = 0;
        int cyc = 0;
        while (got < 40 && cyc < 400) begin
          if (master_en && !master_read) begin
            if (sb.size() == 0) chk("wrap_sb_empty", 0, 1);
            else chk("wrap_data", master_data, sb.pop_front());
            master_read = 1'b1;
            got++;
          end else begin
            master_read = 1'b0;
          end
          tick();
          cyc++;
        end
        master_read = 1'b0;
        if (got < 40) chk("wrap_timeout", got, 40);
      end
      begin
        bit p_both;
        logic [LWIDTH-1:0] p_lvl;
        p_both = 1'b0;
        p_lvl  = '0;
        for (int c = 0; c < 150; c++) begin
          @(negedge clk);
          if (p_both) chk("lvl_stable", host_level, p_lvl);
          p_both = host_wr_en && !host_full && master_read && master_en && (host_level != 0);
          p_lvl  = host_level;
        end
      end
    join
    repeat (3) tick();
    chk("wrap_lvl", host_level, 0);

    // underflow in IDLE, blocked config while VALID
    master_read = 1'b1;
    tick();
    master_read = 1'b0;
    chk("unf_set", underflow, 1);
    chk("unf_en", master_en, 0);
    push(20'h12345, 1'b1);
    wait_en();
    cfg_wr = 1'b1;
    cfg_in = 2'b01;
    tick();
    cfg_wr = 1'b0;
    chk("cfg_blocked", master_cfg, 3);

    // flush mid-stream together with a push
    for (int i = 0; i < 5; i++) push(CWIDTH'(20'h2A000 + i), 1'b1);
    chk("pre_fl_lvl", host_level, 5);
    chk("pre_fl_en", master_en, 1);
    flush      = 1'b1;
    host_wr_en = 1'b1;
    host_wdata = 20'h77777;
    tick();
    flush      = 1'b0;
    host_wr_en = 1'b0;
    sb.delete();
    chk("fl_en", master_en, 0);
    chk("fl_lvl", host_level, 0);
    chk("fl_ovf", overflow, 0);
    chk("fl_unf", underflow, 0);
    chk("fl_data", master_data, 0);
    chk("fl_cfg", master_cfg, 3);
    repeat (3) tick();
    chk("fl_discard_en", master_en, 0);
    chk("fl_discard_lvl", host_level, 0);

    // async reset while a word is presented
    push(20'h0BEEF, 1'b1);
    wait_en();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_en", master_en, 0);
    chk("arst_data", master_data, 0);
    chk("arst_cfg", master_cfg, 0);
    sb.delete();
    #2 rst_n = 1'b1;
    tick();
    chk("arst_lvl", host_level, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
